fpu_sequencer: RTL

Issue sequencer for the floating-point datapath in the execute stage. Accepts one FPU operation at a time and latches its operands onto the shared unit inputs. Single-cycle units complete on a fixed schedule; the iterative fdiv/fsqrt units are sequenced through a start/done handshake with a timeout. Produces one write-back pulse per operation, carrying the float result and the compare flags.

---
 rtl/fpu_sequencer_pkg.sv | 28 ++
 rtl/fpu_sequencer_if.sv | 41 ++++
 rtl/fpu_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fpu_sequencer_pkg.sv
// Shared FPU definitions: float opcodes, sequencer state encoding and the canonical qNaN.
package fpu_sequencer_pkg;

    localparam logic [3:0] FLOAT_FADD  = 4'd0;
    localparam logic [3:0] FLOAT_FSUB  = 4'd1;
    localparam logic [3:0] FLOAT_FMUL  = 4'd2;
    localparam logic [3:0] FLOAT_FDIV  = 4'd3;
    localparam logic [3:0] FLOAT_FSQRT = 4'd4;
    localparam logic [3:0] FLOAT_FMIN  = 4'd5;
    localparam logic [3:0] FLOAT_FMAX  = 4'd6;
    localparam logic [3:0] FLOAT_FCMP  = 4'd7;

    localparam logic [31:0] FLOAT_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FAST  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // fdiv/fsqrt go through the start/done handshake, everything else is single-cycle.
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == FLOAT_FDIV) || (op == FLOAT_FSQRT);
    endfunction

endpackage

// File: rtl/fpu_sequencer_if.sv
// Request, unit-handshake and write-back signals between the sequencer and the FPU datapath.
interface fpu_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [DATA_W-1:0] req_x1;
    logic [DATA_W-1:0] req_x2;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] x1_q;
    logic [DATA_W-1:0] x2_q;
    logic [DATA_W-1:0] fast_result;
    logic              fsub_sign;
    logic              div_start;
    logic              sqrt_start;
    logic              div_done;
    logic              sqrt_done;
    logic [DATA_W-1:0] div_result;
    logic [DATA_W-1:0] sqrt_result;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic [3:0]        wb_cr;
    logic              busy;
    logic              err_timeout;

    modport slave (
        input  req_valid, req_op, req_x1, req_x2, fast_result, fsub_sign,
               div_done, sqrt_done, div_result, sqrt_result,
        output req_ready, op_q, x1_q, x2_q, div_start, sqrt_start,
               wb_valid, wb_data, wb_cr, busy, err_timeout
    );

    modport master (
        output req_valid, req_op, req_x1, req_x2, fast_result, fsub_sign,
               div_done, sqrt_done, div_result, sqrt_result,
        input  req_ready, op_q, x1_q, x2_q, div_start, sqrt_start,
               wb_valid, wb_data, wb_cr, busy, err_timeout
    );

endinterface

// File: rtl/fpu_sequencer.sv
// Execute-stage FPU issue sequencer: latches one operation, schedules single-cycle units
// directly and drives fdiv/fsqrt through a start/done handshake bounded by a timeout.
module fpu_sequencer
    import fpu_sequencer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 63
) (
    input  logic            clk,
    input  logic            rstn,
    fpu_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    seq_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] x1_q, x2_q;
    logic [DATA_W-1:0] wb_data;
    logic [3:0]        wb_cr;
    logic              wb_valid, div_start, sqrt_start, err_timeout;

    logic              sel_done, cnt_hit;
    logic [DATA_W-1:0] sel_result;
    logic              wb_valid_nxt, div_start_nxt, sqrt_start_nxt;
    logic              ld_fast, ld_unit, ld_tmo;

    // Compare flags: 0010 equal, 1000 less (x1-x2 negative), 0100 greater.
    function automatic logic [3:0] cmp_flags(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic neg);
        if (a == b)  return 4'b0010;
        else if (neg) return 4'b1000;
        else          return 4'b0100;
    endfunction

    // Only the unit matching the latched opcode can complete the operation.
    assign sel_done   = (op_q == FLOAT_FDIV) ? bus.div_done   : bus.sqrt_done;
    assign sel_result = (op_q == FLOAT_FDIV) ? bus.div_result : bus.sqrt_result;
    assign cnt_hit    = (cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.req_valid)
                          state_nxt = is_iterative(bus.req_op) ? ST_START : ST_FAST;
            ST_FAST:  state_nxt = ST_DONE;
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT:  if (sel_done || cnt_hit) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        div_start_nxt  = 1'b0;
        sqrt_start_nxt = 1'b0;
        wb_valid_nxt   = 1'b0;
        ld_fast        = 1'b0;
        ld_unit        = 1'b0;
        ld_tmo         = 1'b0;
        case (state)
            ST_IDLE: begin
                div_start_nxt  = bus.req_valid && (bus.req_op == FLOAT_FDIV);
                sqrt_start_nxt = bus.req_valid && (bus.req_op == FLOAT_FSQRT);
            end
            ST_FAST: begin
                ld_fast      = 1'b1;
                wb_valid_nxt = 1'b1;
            end
            ST_WAIT: begin
                ld_unit      = sel_done;
                ld_tmo       = !sel_done && cnt_hit;
                wb_valid_nxt = sel_done || cnt_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q        <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            cnt         <= '0;
            wb_valid    <= 1'b0;
            div_start   <= 1'b0;
            sqrt_start  <= 1'b0;
            wb_data     <= '0;
            wb_cr       <= '0;
            err_timeout <= 1'b0;
        end else begin
            wb_valid   <= wb_valid_nxt;
            div_start  <= div_start_nxt;
            sqrt_start <= sqrt_start_nxt;
            if (bus.req_valid && (state == ST_IDLE)) begin
                op_q <= bus.req_op;
                x1_q <= bus.req_x1;
                x2_q <= bus.req_x2;
            end
            if (state == ST_START)
                cnt <= '0;
            else if ((state == ST_WAIT) && !sel_done && !cnt_hit)
                cnt <= cnt + 1'b1;
            if (ld_fast) begin
                wb_data <= bus.fast_result;
                wb_cr   <= cmp_flags(x1_q, x2_q, bus.fsub_sign);
            end
            if (ld_unit) begin
                wb_data <= sel_result;
                wb_cr   <= 4'b0010;
            end
            // Timeout aborts with a quiet NaN and leaves a sticky error until reset.
            if (ld_tmo) begin
                wb_data     <= DATA_W'(FLOAT_QNAN);
                err_timeout <= 1'b1;
            end
        end
    end

    assign bus.req_ready   = (state == ST_IDLE);
    assign bus.busy        = (state != ST_IDLE);
    assign bus.op_q        = op_q;
    assign bus.x1_q        = x1_q;
    assign bus.x2_q        = x2_q;
    assign bus.div_start   = div_start;
    assign bus.sqrt_start  = sqrt_start;
    assign bus.wb_valid    = wb_valid;
    assign bus.wb_data     = wb_data;
    assign bus.wb_cr       = wb_cr;
    assign bus.err_timeout = err_timeout;

endmodule
